// File: rtl/gba_audio_pkg.sv
// rtl/gba_audio_pkg.sv - shared constants and helpers for the GBA audio sample path
package gba_audio_pkg;

  localparam int AUDIO_WORD_W = 16;
  localparam int COUNT_W      = 8;

  // Word presented when nothing valid is available (reset, flush, underrun).
  localparam logic [AUDIO_WORD_W-1:0] SILENCE_WORD = 16'h0000;

  // Byte address of the cartridge audio window, shared with the ROM responder.
  localparam logic [23:0] AUDIO_WINDOW_BASE = 24'h7F_FF80;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// rtl/audio_fifo_ram.sv - simple dual-port word store with a registered read port
module audio_fifo_ram
  import gba_audio_pkg::*;
#(
  parameter int                        ADDR_W     = 9,
  parameter logic [AUDIO_WORD_W-1:0]   RESET_WORD = SILENCE_WORD
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [AUDIO_WORD_W-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic                    rd_silence_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic [AUDIO_WORD_W-1:0] rd_data_o
);

  logic [AUDIO_WORD_W-1:0] mem_q [1<<ADDR_W];
  logic [AUDIO_WORD_W-1:0] rd_data_q;

  // Write port; contents are not reset, validity is tracked by the owner.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: old data on a same-address write, silence takes precedence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= RESET_WORD;
    end else if (rd_silence_i) begin
      rd_data_q <= RESET_WORD;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gba_audio_sample_fifo.sv
// rtl/gba_audio_sample_fifo.sv - audio word FIFO feeding the ROM responder's sample input
module gba_audio_sample_fifo
  import gba_audio_pkg::*;
#(
  parameter int                      DEPTH_LOG2        = 9,
  parameter int                      ALMOST_FULL_LEVEL = 448,
  parameter logic [AUDIO_WORD_W-1:0] SILENCE_WORD      = gba_audio_pkg::SILENCE_WORD
) (
  input  logic                    IwClk,
  input  logic                    IwReset,
  input  logic                    IwWrEn,
  input  logic [AUDIO_WORD_W-1:0] IbWrData,
  input  logic                    IwFlush,
  input  logic                    IwClearFlags,
  input  logic                    IwNextSamples,
  output logic [AUDIO_WORD_W-1:0] ObSamples,
  output logic [DEPTH_LOG2:0]     ObLevel,
  output logic                    OwEmpty,
  output logic                    OwFull,
  output logic                    OwAlmostFull,
  output logic                    OwUnderrun,
  output logic                    OwOverflow,
  output logic [COUNT_W-1:0]      ObUnderrunCount,
  output logic [COUNT_W-1:0]      ObOverflowCount
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(1 << DEPTH_LOG2);
  localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(ALMOST_FULL_LEVEL);

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  hist_q;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;
  logic [COUNT_W-1:0]    ucnt_q, ucnt_d;
  logic [COUNT_W-1:0]    ocnt_q, ocnt_d;

  logic empty, full, pop;
  logic pop_ok, wr_ok, underrun_ev, overflow_ev;

  // Event decode, pointer/level next state and sticky error bookkeeping.
  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == DEPTH_LVL);
    pop         = IwNextSamples & ~hist_q;
    // Flush swallows any same-cycle write or pop without raising flags.
    pop_ok      = pop & ~empty & ~IwFlush;
    underrun_ev = pop & empty & ~IwFlush;
    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    wr_ok       = IwWrEn & ~IwFlush & (~full | pop);
    overflow_ev = IwWrEn & ~IwFlush & full & ~pop;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (IwFlush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Clear first, then let a same-cycle event re-set flag and count to 1.
    underrun_d = IwClearFlags ? 1'b0 : underrun_q;
    overflow_d = IwClearFlags ? 1'b0 : overflow_q;
    ucnt_d     = IwClearFlags ? '0 : ucnt_q;
    ocnt_d     = IwClearFlags ? '0 : ocnt_q;
    if (underrun_ev) begin
      underrun_d = 1'b1;
      ucnt_d     = sat_inc(ucnt_d);
    end
    if (overflow_ev) begin
      overflow_d = 1'b1;
      ocnt_d     = sat_inc(ocnt_d);
    end
  end

  // State registers; reset discards all stored words.
  always_ff @(posedge IwClk or posedge IwReset) begin
    if (IwReset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      hist_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      ucnt_q     <= '0;
      ocnt_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      hist_q     <= IwNextSamples;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      ucnt_q     <= ucnt_d;
      ocnt_q     <= ocnt_d;
    end
  end

  audio_fifo_ram #(
    .ADDR_W     (DEPTH_LOG2),
    .RESET_WORD (SILENCE_WORD)
  ) u_ram (
    .clk_i        (IwClk),
    .rst_i        (IwReset),
    .wr_en_i      (wr_ok),
    .wr_addr_i    (wr_ptr_q),
    .wr_data_i    (IbWrData),
    .rd_en_i      (pop_ok),
    .rd_silence_i (IwFlush | underrun_ev),
    .rd_addr_i    (rd_ptr_q),
    .rd_data_o    (ObSamples)
  );

  assign ObLevel         = level_q;
  assign OwEmpty         = empty;
  assign OwFull          = full;
  assign OwAlmostFull    = (level_q >= AF_LVL);
  assign OwUnderrun      = underrun_q;
  assign OwOverflow      = overflow_q;
  assign ObUnderrunCount = ucnt_q;
  assign ObOverflowCount = ocnt_q;

endmodule

// File: tb/tb_gba_audio_sample_fifo.sv
// tb/tb_gba_audio_sample_fifo.sv - directed self-checking bench for gba_audio_sample_fifo
module tb_gba_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        flush;
  logic        clear_flags;
  logic        next_samples;
  logic [15:0] samples;
  logic [9:0]  level;
  logic        empty, full, almost_full, underrun, overflow;
  logic [7:0]  ucnt, ocnt;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  always #5 clk = ~clk;

  gba_audio_sample_fifo dut (
    .IwClk           (clk),
    .IwReset         (rst),
    .IwWrEn          (wr_en),
    .IbWrData        (wr_data),
    .IwFlush         (flush),
    .IwClearFlags    (clear_flags),
    .IwNextSamples   (next_samples),
    .ObSamples       (samples),
    .ObLevel         (level),
    .OwEmpty         (empty),
    .OwFull          (full),
    .OwAlmostFull    (almost_full),
    .OwUnderrun      (underrun),
    .OwOverflow      (overflow),
    .ObUnderrunCount (ucnt),
    .ObOverflowCount (ocnt)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pop_edge();
    next_samples = 1'b1;
    tick();
    next_samples = 1'b0;
    tick();
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    clear_flags = 1'b0; next_samples = 1'b0;
    tick(); tick();

    // reset state
    expect_eq("rst_samples", samples, 16'h0000);
    expect_eq("rst_level", level, 0);
    expect_eq("rst_empty", empty, 1);
    expect_eq("rst_full", full, 0);
    expect_eq("rst_flags", {underrun, overflow}, 0);
    expect_eq("rst_counts", {ucnt, ocnt}, 0);
    rst = 1'b0;
    tick();

    // three words, three spaced edges, one-cycle latency
    write_word(16'h1111);
    write_word(16'h2222);
    write_word(16'h3333);
    expect_eq("lvl3", level, 3);
    next_samples = 1'b1; tick();
    expect_eq("pop1", samples, 16'h1111);
    expect_eq("pop1_lvl", level, 2);
    next_samples = 1'b0;
    repeat (9) tick();
    expect_eq("hold1", samples, 16'h1111);
    next_samples = 1'b1; tick();
    expect_eq("pop2", samples, 16'h2222);
    expect_eq("pop2_lvl", level, 1);
    next_samples = 1'b0;
    repeat (9) tick();
    next_samples = 1'b1; tick();
    expect_eq("pop3", samples, 16'h3333);
    expect_eq("pop3_lvl", level, 0);
    next_samples = 1'b0;
    tick();
    expect_eq("no_flags", {underrun, overflow}, 0);

    // strobe held high: exactly one pop
    write_word(16'hAAAA);
    write_word(16'hBBBB);
    next_samples = 1'b1;
    repeat (20) tick();
    expect_eq("held_lvl", level, 1);
    expect_eq("held_samples", samples, 16'hAAAA);
    next_samples = 1'b0;
    tick();
    pop_edge();
    expect_eq("drain_b", samples, 16'hBBBB);

    // underrun on empty, then clear
    pop_edge();
    pop_edge();
    expect_eq("ur_samples", samples, 16'h0000);
    expect_eq("ur_flag", underrun, 1);
    expect_eq("ur_count", ucnt, 2);
    expect_eq("ur_level", level, 0);
    pulse_clear();
    expect_eq("clr_flag", underrun, 0);
    expect_eq("clr_count", ucnt, 0);

    // clear coinciding with an underrun: event wins
    next_samples = 1'b1; clear_flags = 1'b1;
    tick();
    next_samples = 1'b0; clear_flags = 1'b0;
    tick();
    expect_eq("clr_ev_flag", underrun, 1);
    expect_eq("clr_ev_count", ucnt, 1);
    pulse_clear();

    // fill to full with almost-full threshold, overflow, drain with wrap
    for (int i = 0; i < 512; i++) begin
      write_word(i[15:0]);
      if (i + 1 == 447) expect_eq("af_447", almost_full, 0);
      if (i + 1 == 448) expect_eq("af_448", almost_full, 1);
      if (i + 1 == 511) expect_eq("full_511", full, 0);
    end
    expect_eq("full_512", full, 1);
    expect_eq("lvl_512", level, 512);
    write_word(16'hDEAD);
    expect_eq("ovf_lvl", level, 512);
    expect_eq("ovf_flag", overflow, 1);
    expect_eq("ovf_count", ocnt, 1);
    for (int i = 0; i < 512; i++) begin
      pop_edge();
      expect_eq("drain512", samples, i);
    end
    expect_eq("drained_empty", empty, 1);
    expect_eq("drained_ur", underrun, 0);
    pulse_clear();
    expect_eq("ovf_cleared", {overflow, ocnt}, 0);

    // full FIFO: write and pop in the same cycle
    for (int i = 0; i < 512; i++) write_word(i[15:0]);
    wr_en = 1'b1; wr_data = 16'hBEEF; next_samples = 1'b1;
    tick();
    wr_en = 1'b0; next_samples = 1'b0;
    tick();
    expect_eq("fullrw_lvl", level, 512);
    expect_eq("fullrw_ovf", overflow, 0);
    expect_eq("fullrw_samples", samples, 16'h0000);
    for (int i = 1; i < 512; i++) begin
      pop_edge();
      expect_eq("fullrw_drain", samples, i);
    end
    pop_edge();
    expect_eq("fullrw_beef", samples, 16'hBEEF);
    expect_eq("fullrw_empty", level, 0);

    // empty FIFO: write and pop in the same cycle
    wr_en = 1'b1; wr_data = 16'h5555; next_samples = 1'b1;
    tick();
    wr_en = 1'b0; next_samples = 1'b0;
    tick();
    expect_eq("emptyrw_lvl", level, 1);
    expect_eq("emptyrw_ur", underrun, 1);
    expect_eq("emptyrw_samples", samples, 16'h0000);
    pulse_clear();

    // flush at level 5 with same-cycle write and pop edge
    for (int i = 0; i < 4; i++) write_word(16'h6000 + i[15:0]);
    expect_eq("pre_flush_lvl", level, 5);
    pop_edge();
    expect_eq("pre_flush_samples", samples, 16'h5555);
    write_word(16'h6004);
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'h7777; next_samples = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0; next_samples = 1'b0;
    tick();
    expect_eq("flush_lvl", level, 0);
    expect_eq("flush_samples", samples, 16'h0000);
    expect_eq("flush_flags", {underrun, overflow}, 0);
    expect_eq("flush_counts", {ucnt, ocnt}, 0);
    write_word(16'h1234);
    pop_edge();
    expect_eq("post_flush_word", samples, 16'h1234);

    // async reset mid-stream
    pop_edge();
    write_word(16'h4321);
    write_word(16'h5678);
    pop_edge();
    expect_eq("pre_rst_samples", samples, 16'h4321);
    expect_eq("pre_rst_ucnt", ucnt, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    expect_eq("arst_samples", samples, 16'h0000);
    expect_eq("arst_level", level, 0);
    expect_eq("arst_empty", empty, 1);
    expect_eq("arst_flags", {underrun, overflow}, 0);
    expect_eq("arst_counts", {ucnt, ocnt}, 0);
    tick();
    rst = 1'b0;
    tick();
    write_word(16'h9ABC);
    pop_edge();
    expect_eq("post_rst_word", samples, 16'h9ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
